frame_sequencer: RTL and testbench
==================================

Name: frame_sequencer

Overview:
- Sequences the UART-fed message path between the UART receiver, the processing datapath and the UART transmitter.
- Parses framed input: SYNC byte, LEN byte, then LEN payload bytes.
- Buffers the payload, feeds it through the datapath (or loops it back, depending on mode), and transmits the result bytes back over UART.
- Sits between uart_rx/uart_tx and the datapath inside main.

Parameters:
- CLKS_PER_BIT, 640: UART bit time in in_clk cycles; used for the inter-byte timeout.
- MAX_LEN, 16: maximum payload bytes; buffer depth.
- SYNC_BYTE, 8'h3F: frame start marker.
- TIMEOUT_BITS, 20: inter-byte gap limit in bit times; timeout = TIMEOUT_BITS*CLKS_PER_BIT cycles.

Ports:
- in_clk, input, 1: system clock.
- in_reset, input, 1: asynchronous, active-low reset.
- in_mode, input, 2: 00 disabled, 01 loopback, 10 process, 11 process+header echo.
- rx_dv, input, 1: one-cycle pulse; rx_byte is valid.
- rx_byte, input, 8: received byte.
- dp_valid, output, 1: dp_byte is valid for the datapath.
- dp_byte, output, 8: payload byte to the datapath.
- dp_ready, input, 1: datapath accepts dp_byte when dp_valid & dp_ready.
- dp_res_valid, input, 1: one-cycle pulse; dp_res_byte is valid.
- dp_res_byte, input, 8: datapath result byte; exactly one per accepted input byte.
- tx_start, output, 1: one-cycle pulse; tx_byte is presented to uart_tx.
- tx_byte, output, 8: byte to transmit.
- tx_active, input, 1: uart_tx is busy.
- tx_done, input, 1: one-cycle pulse at the end of the stop bit.
- busy, output, 1: high in every state except S_IDLE.
- err, output, 1: one-cycle pulse on a framing error.
- overrun, output, 1: sticky; set when a byte is dropped in S_PROC/S_SEND; cleared at the next accepted SYNC.
- frame_cnt, output, 8: completed frames; wraps 255→0.

Behaviour:
- Reset: in_reset low clears everything asynchronously.
  - All outputs 0; tx_byte and dp_byte are 0.
  - State S_IDLE; buffer contents are don't-care.
  - Reset mid-frame abandons the frame; no tx_start is issued after reset deasserts until a new frame completes.
- States: S_IDLE → S_LEN → S_PAYLOAD → S_PROC → S_SEND → S_IDLE.
- S_IDLE:
  - rx_dv with rx_byte==SYNC_BYTE and in_mode!=00: latch in_mode into mode_q, clear overrun, go to S_LEN.
  - Any other byte is ignored.
  - in_mode is sampled only here; mid-frame mode changes have no effect.
- S_LEN: on rx_dv, handle LEN.
  - LEN==0 or LEN>MAX_LEN: err pulse, back to S_IDLE.
  - Otherwise store LEN, set idx=0, go to S_PAYLOAD.
- S_PAYLOAD: each rx_dv writes buf[idx] and increments idx; when idx reaches LEN, go to S_PROC on the next cycle.
- Timeout in S_LEN/S_PAYLOAD:
  - The counter restarts on every rx_dv.
  - When it reaches TIMEOUT_BITS*CLKS_PER_BIT: err pulse, go to S_IDLE.
  - If rx_dv and the terminal count occur in the same cycle, rx_dv wins.
- S_PROC:
  - mode_q==01: skip directly to S_SEND.
  - Otherwise present buf[i] with dp_valid held until dp_ready; at most one outstanding byte.
  - Each dp_res_valid writes dp_res_byte back to buf[i]; the next byte is issued one cycle later.
  - After LEN results, go to S_SEND.
- S_SEND:
  - Sequence is SYNC_BYTE, then LEN (mode_q==11 only), then buf[0..LEN-1].
  - tx_start pulses for one cycle only when tx_active==0 and the previous byte's tx_done has been seen.
  - tx_byte is stable from tx_start until tx_done.
  - After the last tx_done: frame_cnt+1, go to S_IDLE.
- rx_dv in S_PROC/S_SEND: the byte is discarded and overrun is set (no re-sync).
- Latency: first dp_valid 1 cycle after the last payload byte; first tx_start ≤2 cycles after entering S_SEND.

Decomposition:
- Package frame_pkg holds:
  - state localparams S_IDLE..S_SEND;
  - mode codes MODE_OFF/LOOP/PROC/PROC_HDR;
  - the default SYNC_BYTE;
  - the clog2-based IDX_W width derived from MAX_LEN.
- One sub-module, frame_buffer:
  - MAX_LEN×8 single-port register array;
  - synchronous write, combinational read, index width IDX_W.

Test Plan:
- Mode 01, rx 3F 03 33 FF E4 → tx_start sequence 3F 33 FF E4, each byte after the prior tx_done; frame_cnt=1; dp_valid never asserted.
- Mode 11, same frame, datapath model returns input XOR 8'hFF with dp_ready stalled 5 cycles per byte → tx 3F 03 CC 00 1B; frame_cnt=1.
- Mode 10, frame 3F 03 33 FF E4, then B7 A9 B1 arriving during S_SEND → tx 3F CC 00 1B with no LEN byte, overrun=1; the next accepted SYNC clears overrun.
- Rx 3F 00 and rx 3F 11 (LEN=17, MAX_LEN=16) → one err pulse each, busy back to 0, no tx_start.
- Rx 3F 03 33, then 20 bit times idle → err pulse at exactly 12800 cycles after the last rx_dv; state S_IDLE; subsequent 3F 01 AA in mode 01 → tx 3F AA.
- in_reset low while S_SEND is mid-byte → all outputs 0 immediately (tx_start, dp_valid, busy, overrun, frame_cnt); no further tx_start after release; mode 00 with rx 3F 01 AA → no response.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared types and constants for the UART frame sequencer.
// No logic: enums for FSM state, mode and transmit phase, plus sizing helpers.
// Not applicable: holds no datapath, so no backpressure.
package frame_pkg;

    // Sequencer FSM states
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN     = 3'd1,
        S_PAYLOAD = 3'd2,
        S_PROC    = 3'd3,
        S_SEND    = 3'd4
    } state_t;

    // Operating mode, sampled from in_mode when a SYNC byte is accepted
    typedef enum logic [1:0] {
        MODE_OFF      = 2'b00,
        MODE_LOOP     = 2'b01,
        MODE_PROC     = 2'b10,
        MODE_PROC_HDR = 2'b11
    } mode_t;

    // Which byte of the reply frame goes out next
    typedef enum logic [1:0] {
        PH_SYNC = 2'd0,
        PH_LEN  = 2'd1,
        PH_PAY  = 2'd2
    } send_ph_t;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'h3F;
    localparam int         DEF_MAX_LEN   = 16;

    // Address width for a buffer of the given depth (never below one bit)
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int IDX_W = idx_w(DEF_MAX_LEN);

endpackage

// File: rtl/frame_sequencer_if.sv
// Bundles the UART rx/tx, datapath and status signals of the frame sequencer.
// Wires only, no latency.
// Datapath side uses valid/ready; UART tx side is paced by tx_active/tx_done.
interface frame_sequencer_if;

    logic [1:0] in_mode;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       dp_valid;
    logic [7:0] dp_byte;
    logic       dp_ready;
    logic       dp_res_valid;
    logic [7:0] dp_res_byte;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic       tx_active;
    logic       tx_done;
    logic       busy;
    logic       err;
    logic       overrun;
    logic [7:0] frame_cnt;

    // Sequencer side
    modport master (
        input  in_mode, rx_dv, rx_byte, dp_ready, dp_res_valid, dp_res_byte,
               tx_active, tx_done,
        output dp_valid, dp_byte, tx_start, tx_byte, busy, err, overrun, frame_cnt
    );

    // Environment side (UART blocks, datapath, controller)
    modport slave (
        output in_mode, rx_dv, rx_byte, dp_ready, dp_res_valid, dp_res_byte,
               tx_active, tx_done,
        input  dp_valid, dp_byte, tx_start, tx_byte, busy, err, overrun, frame_cnt
    );

endinterface

// File: rtl/frame_buffer.sv
// Payload store: DEPTH x 8 register array behind a single shared address.
// Write lands on the clock edge; read data is combinational from the address.
// No backpressure: one access per cycle, the owner sequences reads and writes.
module frame_buffer
    import frame_pkg::*;
#(
    parameter int DEPTH = DEF_MAX_LEN,
    parameter int AW    = IDX_W
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [7:0]    wdat_i,
    output logic [7:0]    rdat_o
);

    logic [7:0] mem_q [DEPTH];

    // Contents are don't-care after reset, so the array carries no reset
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdat_i;
        end
    end

    assign rdat_o = mem_q[addr_i];

endmodule

// File: rtl/frame_sequencer.sv
// Parses SYNC/LEN/payload frames from uart_rx, runs the payload through the datapath, replies via uart_tx.
// First dp_valid 1 cycle after the last payload byte; first tx_start 2 cycles after entering S_SEND.
// dp_valid holds until dp_ready, one byte outstanding; tx paced by tx_done; rx bytes while busy are dropped.
module frame_sequencer
    import frame_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 640,
    parameter int         MAX_LEN      = DEF_MAX_LEN,
    parameter logic [7:0] SYNC_BYTE    = DEF_SYNC_BYTE,
    parameter int         TIMEOUT_BITS = 20
) (
    input  logic              in_clk,
    input  logic              in_reset,
    frame_sequencer_if.master bus
);

    localparam int            AW       = idx_w(MAX_LEN);
    localparam int            TMO_CYC  = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int            TW       = $clog2(TMO_CYC + 1);
    // tmo_q counts cycles since the last rx_dv cycle; err must show TMO_CYC cycles after it
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

    state_t     state_q, state_d;
    mode_t      mode_q, mode_d;
    send_ph_t   ph_q, ph_d;
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   idx_q, idx_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic       outst_q, outst_d;
    logic       inflight_q, inflight_d;
    logic       tx_start_q, tx_start_d;
    logic [7:0] tx_byte_q, tx_byte_d;
    logic       err_q, err_d;
    logic       overrun_q, overrun_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;

    logic       buf_we;
    logic [7:0] buf_wdat;
    logic [7:0] buf_rdat;
    logic       dp_valid_c;
    logic       dp_accept;

    // One shared index addresses the buffer in every state: write in
    // S_PAYLOAD, read/write-back in S_PROC, read in S_SEND.
    frame_buffer #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk_i  (in_clk),
        .we_i   (buf_we),
        .addr_i (idx_q[AW-1:0]),
        .wdat_i (buf_wdat),
        .rdat_o (buf_rdat)
    );

    // State register and all sequencer flops
    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            state_q     <= S_IDLE;
            mode_q      <= MODE_OFF;
            ph_q        <= PH_SYNC;
            len_q       <= '0;
            idx_q       <= '0;
            tmo_q       <= '0;
            outst_q     <= 1'b0;
            inflight_q  <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_byte_q   <= 8'h00;
            err_q       <= 1'b0;
            overrun_q   <= 1'b0;
            frame_cnt_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            ph_q        <= ph_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            tmo_q       <= tmo_d;
            outst_q     <= outst_d;
            inflight_q  <= inflight_d;
            tx_start_q  <= tx_start_d;
            tx_byte_q   <= tx_byte_d;
            err_q       <= err_d;
            overrun_q   <= overrun_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Next-state, buffer control and datapath handshake
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        ph_d        = ph_q;
        len_d       = len_q;
        idx_d       = idx_q;
        tmo_d       = '0;
        outst_d     = outst_q;
        inflight_d  = inflight_q;
        tx_start_d  = 1'b0;
        tx_byte_d   = tx_byte_q;
        err_d       = 1'b0;
        overrun_d   = overrun_q;
        frame_cnt_d = frame_cnt_q;
        buf_we      = 1'b0;
        buf_wdat    = bus.rx_byte;
        dp_valid_c  = 1'b0;
        dp_accept   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.rx_dv && (bus.rx_byte == SYNC_BYTE) && (bus.in_mode != MODE_OFF)) begin
                    mode_d    = mode_t'(bus.in_mode);
                    overrun_d = 1'b0;
                    tmo_d     = TW'(1);
                    state_d   = S_LEN;
                end
            end

            S_LEN: begin
                if (bus.rx_dv) begin
                    tmo_d = TW'(1);
                    if ((bus.rx_byte == 8'h00) || (int'(bus.rx_byte) > MAX_LEN)) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        len_d   = bus.rx_byte[AW:0];
                        idx_d   = '0;
                        state_d = S_PAYLOAD;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            S_PAYLOAD: begin
                if (bus.rx_dv) begin
                    tmo_d  = TW'(1);
                    buf_we = 1'b1;
                    if ((idx_q + 1'b1) == len_q) begin
                        idx_d   = '0;
                        outst_d = 1'b0;
                        state_d = S_PROC;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            S_PROC: begin
                overrun_d = overrun_q | bus.rx_dv;
                if (mode_q == MODE_LOOP) begin
                    idx_d      = '0;
                    ph_d       = PH_SYNC;
                    inflight_d = 1'b0;
                    state_d    = S_SEND;
                end else begin
                    dp_valid_c = !outst_q;
                    dp_accept  = dp_valid_c && bus.dp_ready;
                    if (dp_accept) begin
                        outst_d = 1'b1;
                    end
                    // A result can only belong to a byte already handed over
                    if (bus.dp_res_valid && (outst_q || dp_accept)) begin
                        outst_d  = 1'b0;
                        buf_we   = 1'b1;
                        buf_wdat = bus.dp_res_byte;
                        if ((idx_q + 1'b1) == len_q) begin
                            idx_d      = '0;
                            ph_d       = PH_SYNC;
                            inflight_d = 1'b0;
                            state_d    = S_SEND;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
            end

            S_SEND: begin
                overrun_d = overrun_q | bus.rx_dv;
                if (inflight_q) begin
                    if (bus.tx_done) begin
                        inflight_d = 1'b0;
                        if ((ph_q == PH_PAY) && (idx_q == len_q)) begin
                            frame_cnt_d = frame_cnt_q + 8'd1;
                            state_d     = S_IDLE;
                        end
                    end
                end else if (!bus.tx_active) begin
                    tx_start_d = 1'b1;
                    inflight_d = 1'b1;
                    case (ph_q)
                        PH_SYNC: begin
                            tx_byte_d = SYNC_BYTE;
                            ph_d      = (mode_q == MODE_PROC_HDR) ? PH_LEN : PH_PAY;
                        end
                        PH_LEN: begin
                            tx_byte_d = 8'(len_q);
                            ph_d      = PH_PAY;
                        end
                        default: begin
                            tx_byte_d = buf_rdat;
                            idx_d     = idx_q + 1'b1;
                        end
                    endcase
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.dp_valid  = dp_valid_c;
    assign bus.dp_byte   = dp_valid_c ? buf_rdat : 8'h00;
    assign bus.tx_start  = tx_start_q;
    assign bus.tx_byte   = tx_byte_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.err       = err_q;
    assign bus.overrun   = overrun_q;
    assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer with behavioural uart_tx and datapath models.
// Expected reply bytes, counters and timings are written out by hand per scenario.
// Datapath model stalls dp_ready 5 cycles per byte; uart_tx model is busy TX_CYC cycles per byte.
module tb_frame_sequencer;
    import frame_pkg::*;

    localparam int TX_CYC = 12;
    localparam int STALL  = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    frame_sequencer_if bus();

    frame_sequencer #(
        .CLKS_PER_BIT (640),
        .MAX_LEN      (16),
        .SYNC_BYTE    (8'h3F),
        .TIMEOUT_BITS (20)
    ) dut (
        .in_clk   (clk),
        .in_reset (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation of DUT outputs, half a cycle away from the active edge
    logic [7:0] txq[$];
    int err_cnt = 0, last_err_cyc = 0, last_rx_cyc = 0, dpv_cnt = 0;
    always @(negedge clk) begin
        if (bus.tx_start) txq.push_back(bus.tx_byte);
        if (bus.err) begin
            err_cnt      <= err_cnt + 1;
            last_err_cyc <= cyc;
        end
        if (bus.rx_dv) last_rx_cyc <= cyc;
        if (bus.dp_valid) dpv_cnt <= dpv_cnt + 1;
    end

    // uart_tx model: busy for TX_CYC cycles after tx_start, then a tx_done pulse
    int ovl_err = 0, stab_err = 0;
    initial begin : uart_tx_model
        int cnt;
        logic [7:0] cur;
        cnt = 0;
        cur = 8'h00;
        bus.tx_active = 1'b0;
        bus.tx_done   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cnt = 0;
                bus.tx_active = 1'b0;
                bus.tx_done   = 1'b0;
            end else begin
                bus.tx_done = 1'b0;
                if (bus.tx_start) begin
                    if (cnt != 0) ovl_err++;
                    cnt = TX_CYC;
                    cur = bus.tx_byte;
                    bus.tx_active = 1'b1;
                end else if (cnt != 0) begin
                    if (bus.tx_byte !== cur) stab_err++;
                    cnt--;
                    if (cnt == 0) begin
                        bus.tx_done   = 1'b1;
                        bus.tx_active = 1'b0;
                    end
                end
            end
        end
    end

    // Datapath model: result = input XOR FF, dp_ready after STALL cycles of dp_valid
    initial begin : dp_model
        int n, ph;
        logic [7:0] lat;
        n = 0; ph = 0; lat = 8'h00;
        bus.dp_ready = 1'b0; bus.dp_res_valid = 1'b0; bus.dp_res_byte = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                n = 0; ph = 0;
                bus.dp_ready = 1'b0; bus.dp_res_valid = 1'b0;
            end else if (ph == 1) begin
                bus.dp_ready = 1'b0;
                bus.dp_res_valid = 1'b1;
                bus.dp_res_byte  = lat ^ 8'hFF;
                ph = 2;
            end else if (ph == 2) begin
                bus.dp_res_valid = 1'b0;
                ph = 0; n = 0;
            end else if (bus.dp_valid) begin
                if (n < STALL) n++;
                else begin
                    bus.dp_ready = 1'b1;
                    lat = bus.dp_byte;
                    ph = 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        bus.rx_dv = 1'b1; bus.rx_byte = b;
        @(posedge clk); #1;
        bus.rx_dv = 1'b0; bus.rx_byte = 8'h00;
        repeat (2) @(posedge clk);
    endtask

    task automatic do_reset();
        bus.rx_dv = 1'b0; bus.rx_byte = 8'h00;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        @(negedge clk);
        while (bus.busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic wait_tx(input string tag, input int want, input int budget);
        int k = 0;
        while (txq.size() < want && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_txwait"}, 32'(txq.size() >= want), 32'd1);
    endtask

    task automatic expect_tx(input string tag, input int base, input logic [7:0] exp [6], input int n);
        logic [7:0] g;
        chk({tag, "_ntx"}, 32'(txq.size() - base), 32'(n));
        for (int i = 0; i < n; i++) begin
            g = (base + i < txq.size()) ? txq[base + i] : 8'hxx;
            chk($sformatf("%s_tx%0d", tag, i), 32'(g), 32'(exp[i]));
        end
    endtask

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation exceeded 80000 cycles");
        $fatal(1);
    end

    initial begin : main
        int base, e0, d0;
        bus.in_mode = 2'b00; bus.rx_dv = 1'b0; bus.rx_byte = 8'h00;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",     32'(bus.busy),      32'd0);
        chk("rst_tx_start", 32'(bus.tx_start),  32'd0);
        chk("rst_tx_byte",  32'(bus.tx_byte),   32'd0);
        chk("rst_dp_valid", 32'(bus.dp_valid),  32'd0);
        chk("rst_dp_byte",  32'(bus.dp_byte),   32'd0);
        chk("rst_err",      32'(bus.err),       32'd0);
        chk("rst_overrun",  32'(bus.overrun),   32'd0);
        chk("rst_frame",    32'(bus.frame_cnt), 32'd0);

        // Loopback: payload echoed unchanged, datapath untouched
        do_reset();
        bus.in_mode = 2'b01;
        base = txq.size(); d0 = dpv_cnt;
        send_byte(8'h3F); send_byte(8'h03); send_byte(8'h33); send_byte(8'hFF); send_byte(8'hE4);
        wait_idle("t1", 2000);
        expect_tx("t1", base, '{8'h3F, 8'h33, 8'hFF, 8'hE4, 8'h00, 8'h00}, 4);
        chk("t1_frame", 32'(bus.frame_cnt), 32'd1);
        chk("t1_no_dpv", 32'(dpv_cnt - d0), 32'd0);

        // Process with header echo, stalled datapath
        do_reset();
        bus.in_mode = 2'b11;
        base = txq.size(); d0 = dpv_cnt;
        send_byte(8'h3F); send_byte(8'h03); send_byte(8'h33); send_byte(8'hFF); send_byte(8'hE4);
        wait_idle("t2", 2000);
        expect_tx("t2", base, '{8'h3F, 8'h03, 8'hCC, 8'h00, 8'h1B, 8'h00}, 5);
        chk("t2_frame", 32'(bus.frame_cnt), 32'd1);
        chk("t2_dpv_seen", 32'(dpv_cnt != d0), 32'd1);

        // Process without header; mode change mid-frame ignored; bytes during send overrun
        do_reset();
        bus.in_mode = 2'b10;
        base = txq.size();
        send_byte(8'h3F);
        bus.in_mode = 2'b01;
        send_byte(8'h03); send_byte(8'h33); send_byte(8'hFF); send_byte(8'hE4);
        wait_tx("t3", base + 1, 1000);
        send_byte(8'hB7); send_byte(8'hA9); send_byte(8'hB1);
        wait_idle("t3", 2000);
        expect_tx("t3", base, '{8'h3F, 8'hCC, 8'h00, 8'h1B, 8'h00, 8'h00}, 4);
        chk("t3_overrun", 32'(bus.overrun), 32'd1);
        chk("t3_frame", 32'(bus.frame_cnt), 32'd1);
        send_byte(8'h3F);
        chk("t3_ovr_clr", 32'(bus.overrun), 32'd0);
        chk("t3_busy", 32'(bus.busy), 32'd1);

        // Bad LEN values
        do_reset();
        bus.in_mode = 2'b01;
        base = txq.size(); e0 = err_cnt;
        send_byte(8'h3F); send_byte(8'h00);
        @(negedge clk);
        chk("t4_err_len0", 32'(err_cnt - e0), 32'd1);
        chk("t4_busy0", 32'(bus.busy), 32'd0);
        send_byte(8'h3F); send_byte(8'h11);
        @(negedge clk);
        chk("t4_err_len17", 32'(err_cnt - e0), 32'd2);
        chk("t4_busy17", 32'(bus.busy), 32'd0);
        repeat (20) @(posedge clk);
        chk("t4_no_tx", 32'(txq.size() - base), 32'd0);

        // Inter-byte timeout, then recovery
        do_reset();
        bus.in_mode = 2'b01;
        e0 = err_cnt;
        send_byte(8'h3F); send_byte(8'h03); send_byte(8'h33);
        begin
            int k = 0;
            while (err_cnt == e0 && k < 13000) begin
                @(negedge clk);
                k++;
            end
        end
        chk("t5_err", 32'(err_cnt - e0), 32'd1);
        chk("t5_gap", 32'(last_err_cyc - last_rx_cyc), 32'd12800);
        chk("t5_busy", 32'(bus.busy), 32'd0);
        base = txq.size();
        send_byte(8'h3F); send_byte(8'h01); send_byte(8'hAA);
        wait_idle("t5", 2000);
        expect_tx("t5", base, '{8'h3F, 8'hAA, 8'h00, 8'h00, 8'h00, 8'h00}, 2);

        // Async reset in the middle of a transmitted byte
        do_reset();
        bus.in_mode = 2'b01;
        send_byte(8'h3F); send_byte(8'h01); send_byte(8'h55);
        wait_idle("t6a", 2000);
        chk("t6_frame_pre", 32'(bus.frame_cnt), 32'd1);
        base = txq.size();
        send_byte(8'h3F); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22);
        wait_tx("t6", base + 2, 1000);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_tx_start", 32'(bus.tx_start),  32'd0);
        chk("t6_rst_tx_byte",  32'(bus.tx_byte),   32'd0);
        chk("t6_rst_dp_valid", 32'(bus.dp_valid),  32'd0);
        chk("t6_rst_busy",     32'(bus.busy),      32'd0);
        chk("t6_rst_overrun",  32'(bus.overrun),   32'd0);
        chk("t6_rst_frame",    32'(bus.frame_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        base = txq.size();
        repeat (200) @(posedge clk);
        chk("t6_no_tx_after", 32'(txq.size() - base), 32'd0);
        bus.in_mode = 2'b00;
        send_byte(8'h3F);
        chk("t6_off_busy", 32'(bus.busy), 32'd0);
        send_byte(8'h01); send_byte(8'hAA);
        repeat (50) @(posedge clk);
        chk("t6_off_no_tx", 32'(txq.size() - base), 32'd0);
        chk("t6_off_frame", 32'(bus.frame_cnt), 32'd0);

        chk("tx_overlap", 32'(ovl_err), 32'd0);
        chk("tx_byte_stable", 32'(stab_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
